comp_arbiter: RTL and testbench

- Shares one N-bit unsigned magnitude comparator (GT/LT/EQ) between NREQ requesters.
- Uses round-robin arbitration, a request/grant handshake on the input side and a valid/ready handshake on the result side.
- Sits between several client blocks and the single comparator datapath, so only one comparator instance is needed.
- Operands are latched at grant; the result is returned tagged with the requester ID.

---
 rtl/comp_arbiter.sv | 138 +++++++++++++
 tb/tb_comp_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/comp_arbiter.sv
// Round-robin arbiter sharing one unsigned magnitude comparator between NREQ requesters.
// Operands are latched at grant; the tagged result is returned over a valid/ready handshake.
module comp_arbiter #(
  parameter int unsigned N    = 32,
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] a_flat,
  input  logic [NREQ*N-1:0] b_flat,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_gt,
  output logic              rsp_lt,
  output logic              rsp_eq
);

  typedef enum logic [1:0] {StIdle, StCmp, StResp} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [N-1:0]    op_a_q, op_a_d;
  logic [N-1:0]    op_b_q, op_b_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic            rsp_gt_q, rsp_gt_d;
  logic            rsp_lt_q, rsp_lt_d;
  logic            rsp_eq_q, rsp_eq_d;

  logic            req_found;
  logic [IDW-1:0]  win_id;
  logic [IDW-1:0]  scan_id;
  logic [IDW-1:0]  win_next;

  // First set request bit scanning upward from rr_ptr, wrapping at NREQ-1.
  always_comb begin
    req_found = 1'b0;
    win_id    = '0;
    scan_id   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan_id = IDW'((32'(rr_ptr_q) + i) % NREQ);
      if (!req_found && req[scan_id]) begin
        req_found = 1'b1;
        win_id    = scan_id;
      end
    end
  end

  assign win_next = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    id_d        = id_q;
    gnt_d       = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_gt_d    = rsp_gt_q;
    rsp_lt_d    = rsp_lt_q;
    rsp_eq_d    = rsp_eq_q;
    unique case (state_q)
      StIdle: begin
        if (req_found) begin
          op_a_d   = a_flat[32'(win_id) * N +: N];
          op_b_d   = b_flat[32'(win_id) * N +: N];
          id_d     = win_id;
          gnt_d    = NREQ'(1) << win_id;
          rr_ptr_d = win_next;
          state_d  = StCmp;
        end
      end
      StCmp: begin
        rsp_gt_d    = op_a_q > op_b_q;
        rsp_lt_d    = op_a_q < op_b_q;
        rsp_eq_d    = op_a_q == op_b_q;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_gt_d    = 1'b0;
          rsp_lt_d    = 1'b0;
          rsp_eq_d    = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      id_q        <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_gt_q    <= 1'b0;
      rsp_lt_q    <= 1'b0;
      rsp_eq_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      id_q        <= id_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_gt_q    <= rsp_gt_d;
      rsp_lt_q    <= rsp_lt_d;
      rsp_eq_q    <= rsp_eq_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_gt    = rsp_gt_q;
  assign rsp_lt    = rsp_lt_q;
  assign rsp_eq    = rsp_eq_q;

endmodule

// File: tb/tb_comp_arbiter.sv
// Scoreboard bench for comp_arbiter: stimulus pushes expected results, a monitor pops on handshake.
module tb_comp_arbiter;

  localparam int unsigned N    = 32;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           gt;
    logic           lt;
    logic           eq;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] a_flat;
  logic [NREQ*N-1:0] b_flat;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_gt;
  logic              rsp_lt;
  logic              rsp_eq;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb[$];

  comp_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .gnt       (gnt),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_gt    (rsp_gt),
    .rsp_lt    (rsp_lt),
    .rsp_eq    (rsp_eq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input int id, input int code);
    exp_t e;
    e.id = IDW'(id);
    e.gt = (code == 0);
    e.lt = (code == 1);
    e.eq = (code == 2);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input logic [NREQ-1:0] exp_mask, input string name);
    int k = 0;
    do begin
      tick();
      k++;
    end while (gnt == '0 && k < 20);
    if (gnt == '0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no gnt within 20 cycles, expected %b", name, exp_mask);
    end else begin
      check(name, 64'(gnt), 64'(exp_mask));
    end
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 30) begin
      tick();
      k++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: still busy after 30 cycles, expected idle", name);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One isolated request; optionally swaps the operands in the gnt cycle.
  task automatic single(input int k, input logic [N-1:0] a, input logic [N-1:0] b,
                        input int code, input bit perturb, input string name);
    logic [NREQ-1:0] m;
    m = '0;
    m[k] = 1'b1;
    a_flat[k*N +: N] = a;
    b_flat[k*N +: N] = b;
    sb.push_back(mk(k, code));
    req = m;
    wait_gnt(m, {name, "_gnt"});
    req = '0;
    if (perturb) begin
      a_flat[k*N +: N] = b;
      b_flat[k*N +: N] = a;
    end
    tick();
    check({name, "_gnt_pulse"}, 64'(gnt), 64'(0));
    check({name, "_valid"}, 64'(rsp_valid), 64'(1));
    wait_idle(name);
  endtask

  // Monitor: compares against the scoreboard on every accepted response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) check("flag_onehot", 64'(rsp_gt + rsp_lt + rsp_eq), 64'(1));
      else check("flag_idle", 64'({rsp_gt, rsp_lt, rsp_eq}), 64'(0));
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: got id %0d with no expected entry", rsp_id);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp", 64'({rsp_id, rsp_gt, rsp_lt, rsp_eq}), 64'(e));
        end
      end
    end
  end

  initial begin
    int last_cyc;
    rst_n     = 1'b1;
    req       = '0;
    a_flat    = '0;
    b_flat    = '0;
    rsp_ready = 1'b1;
    #1 rst_n  = 1'b0;
    tick();
    tick();
    check("reset_outs", 64'({gnt, busy, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq}), 64'(0));
    rst_n = 1'b1;

    single(0, 32'd5, 32'd3, 0, 1'b0, "single_r0");

    single(2, 32'd233, 32'd345, 1, 1'b0, "r2_lt");
    single(2, 32'd126, 32'd126, 2, 1'b0, "r2_eq");
    single(2, 32'd555, 32'd345, 0, 1'b0, "r2_gt");

    // Full contention from rr_ptr=0.
    do_reset();
    for (int k = 0; k < NREQ; k++) begin
      a_flat[k*N +: N] = 32'(k + 10);
      b_flat[k*N +: N] = 32'd10;
    end
    for (int i = 0; i < 5; i++) sb.push_back(mk(i % 4, (i % 4 == 0) ? 2 : 0));
    req = 4'hF;
    last_cyc = 0;
    for (int i = 0; i < 5; i++) begin
      logic [NREQ-1:0] m;
      m = '0;
      m[i % 4] = 1'b1;
      wait_gnt(m, "rr_gnt");
      if (i > 0) check("rr_spacing", 64'(cyc - last_cyc), 64'(3));
      last_cyc = cyc;
      if (i == 4) req = '0;
    end
    wait_idle("rr");

    // Backpressure with a competing request arriving during RESP.
    rsp_ready = 1'b0;
    a_flat[1*N +: N] = 32'd555;
    b_flat[1*N +: N] = 32'd590;
    sb.push_back(mk(1, 1));
    req = 4'b0010;
    wait_gnt(4'b0010, "bp_gnt");
    req = '0;
    tick();
    a_flat[3*N +: N] = 32'd7;
    b_flat[3*N +: N] = 32'd7;
    req = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", 64'({rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, gnt}),
            64'({1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 4'b0000}));
      tick();
    end
    sb.push_back(mk(3, 2));
    rsp_ready = 1'b1;
    tick();
    check("bp_idle", 64'({busy, gnt}), 64'(0));
    tick();
    check("bp_r3_gnt", 64'(gnt), 64'(4'b1000));
    req = '0;
    wait_idle("bp");

    // Asynchronous reset during CMP.
    a_flat[1*N +: N] = 32'd9;
    b_flat[1*N +: N] = 32'd1;
    req = 4'b0010;
    wait_gnt(4'b0010, "mid_gnt");
    req = '0;
    #2 rst_n = 1'b0;
    #1 check("mid_reset", 64'({gnt, busy, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq}), 64'(0));
    sb.delete();
    tick();
    rst_n = 1'b1;
    a_flat[0*N +: N] = 32'd1;
    b_flat[0*N +: N] = 32'd2;
    a_flat[3*N +: N] = 32'd50;
    b_flat[3*N +: N] = 32'd0;
    sb.push_back(mk(0, 1));
    req = 4'b1001;
    wait_gnt(4'b0001, "post_reset_gnt");
    req = '0;
    wait_idle("post_reset");

    single(2, 32'hFFFF_FFFF, 32'h0, 0, 1'b0, "max_gt");
    single(2, 32'h0, 32'hFFFF_FFFF, 1, 1'b1, "max_lt_perturb");
    single(1, 32'h0, 32'h0, 2, 1'b0, "zero_eq");

    tick();
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
